// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Issues req/ack instruction reads, buffers one word while ID stalls,
// and drops the stale response of a request that a redirect overtook.
// Optional build macro: FETCH_PERF_CNT_EN adds the PERF_W parameter and the
// perf_stall_cnt / perf_flush_cnt saturating counter ports.
module if_fetch_stage #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0]   NOP_INST = XLEN'(32'h0000_0013)
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int unsigned       PERF_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              ifid_write,
    input  logic              ifid_flush,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              ifid_valid,
    output logic [XLEN-1:0]   ifid_pc,
    output logic [XLEN-1:0]   ifid_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] hold_inst_q;
    logic [XLEN-1:0] drop_pc_q;

    logic            ack_c;
    logic            fetching_c;
    logic            load_fetch_c;
    logic            load_hold_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] pc_inc_c;

    // Fetch address is the PC flop itself, always word aligned
    assign imem_addr = pc_q;

    // Handshake and IF/ID load qualifiers
    assign ack_c        = imem_req & imem_ack;
    assign fetching_c   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign load_fetch_c = !redirect_valid && fetching_c && ack_c && ifid_write;
    assign load_hold_c  = !redirect_valid && (state_q == S_HOLD) && ifid_write;
    assign target_c     = redirect_pc & ~XLEN'(3);
    assign pc_inc_c     = pc_q + XLEN'(4);

    // IF/ID register: flush wins, otherwise load from memory or hold buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_inst  <= NOP_INST;
        end else if (ifid_flush) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_inst  <= NOP_INST;
        end else if (load_fetch_c) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc_q;
            ifid_inst  <= imem_rdata;
        end else if (load_hold_c) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc_q;
            ifid_inst  <= hold_inst_q;
        end
    end

    // Fetch FSM: PC, request line, hold buffer and pending redirect target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC & ~XLEN'(3);
            imem_req    <= 1'b0;
            hold_inst_q <= NOP_INST;
            drop_pc_q   <= '0;
        end else begin
            imem_req <= 1'b1;
            if (redirect_valid) begin
                // A request still awaiting its ack must complete before retargeting
                if (ack_c || !imem_req) begin
                    pc_q    <= target_c;
                    state_q <= S_REQ;
                end else begin
                    drop_pc_q <= target_c;
                    state_q   <= S_DROP;
                end
            end else begin
                case (state_q)
                    S_REQ, S_WAIT: begin
                        if (ack_c) begin
                            if (ifid_flush) begin
                                state_q <= S_REQ;
                            end else if (ifid_write) begin
                                if (pc_write) begin
                                    pc_q <= pc_inc_c;
                                end
                                state_q <= S_REQ;
                            end else begin
                                hold_inst_q <= imem_rdata;
                                imem_req    <= 1'b0;
                                state_q     <= S_HOLD;
                            end
                        end else if (imem_req) begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_HOLD: begin
                        if (ifid_flush) begin
                            state_q <= S_REQ;
                        end else if (ifid_write) begin
                            if (pc_write) begin
                                pc_q <= pc_inc_c;
                            end
                            state_q <= S_REQ;
                        end else begin
                            imem_req <= 1'b0;
                        end
                    end
                    S_DROP: begin
                        if (ack_c) begin
                            pc_q    <= drop_pc_q;
                            state_q <= S_REQ;
                        end
                    end
                    default: state_q <= S_REQ;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of stalled and flushed cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!ifid_write && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
            end
            if (ifid_flush && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by a random run,
// all cycles compared against a transaction-level fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b1;
    logic        ifid_write = 1'b1;
    logic        ifid_flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_inst      (ifid_inst)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // memory responder state
    int lat = 0;          // fixed latency, or -1 for random 0..3
    bit mem_busy = 1'b0;
    int mem_left = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_live;
    logic [31:0] m_hold[$];
    logic [31:0] m_drop[$];
    bit          m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_inst;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_live = 1'b0;
        m_hold.delete();
        m_drop.delete();
        m_v = 1'b0;
        m_ipc = '0;
        m_inst = NOP_INST;
        m_stall = '0;
        m_flush = '0;
    endtask

    function automatic bit model_req();
        return m_live && (m_hold.size() == 0);
    endfunction

    // One clock edge of the fetch stage as seen by ID and memory
    task automatic model_step(input bit pw, input bit iw, input bit fl, input bit rv,
                              input logic [31:0] rpc, input bit ack, input logic [31:0] rd);
        bit          req;
        bit          acc;
        logic [31:0] tgt;
        req = model_req();
        acc = req && ack;
        tgt = rpc & 32'hFFFF_FFFC;
        if (!iw && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (fl && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        if (fl) begin
            m_v = 1'b0; m_ipc = '0; m_inst = NOP_INST;
        end else if (!rv && iw) begin
            if (m_hold.size() != 0) begin
                m_v = 1'b1; m_ipc = m_pc; m_inst = m_hold[0];
            end else if (m_drop.size() == 0 && acc) begin
                m_v = 1'b1; m_ipc = m_pc; m_inst = rd;
            end
        end
        if (rv) begin
            if (acc || !req) begin
                m_pc = tgt; m_hold.delete(); m_drop.delete();
            end else begin
                m_drop.delete(); m_drop.push_back(tgt);
            end
        end else if (m_drop.size() != 0) begin
            if (acc) m_pc = m_drop.pop_front();
        end else if (m_hold.size() != 0) begin
            if (fl) m_hold.delete();
            else if (iw) begin
                m_hold.delete();
                if (pw) m_pc = m_pc + 32'd4;
            end
        end else if (acc && !fl) begin
            if (iw) begin
                if (pw) m_pc = m_pc + 32'd4;
            end else m_hold.push_back(rd);
        end
        m_live = 1'b1;
    endtask

    task automatic check_all();
        chk("req", {31'b0, imem_req}, {31'b0, model_req()});
        if (model_req()) chk("addr", imem_addr, m_pc);
        chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_inst", ifid_inst, m_inst);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, m_stall);
        chk("perf_flush", perf_flush_cnt, m_flush);
`endif
    endtask

    // Drive one cycle of hazard inputs plus the memory response, then check
    task automatic cycle(input bit pw, input bit iw, input bit fl, input bit rv, input logic [31:0] rpc);
        bit          ak;
        logic [31:0] rd;
        @(negedge clk);
        pc_write = pw; ifid_write = iw; ifid_flush = fl;
        redirect_valid = rv; redirect_pc = rpc;
        ak = 1'b0;
        rd = $urandom;
        if (imem_req === 1'b1) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_left = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            end
            if (mem_left == 0) begin
                ak = 1'b1; rd = word(imem_addr); mem_busy = 1'b0;
            end else mem_left--;
        end else mem_busy = 1'b0;
        imem_ack = ak; imem_rdata = rd;
        @(posedge clk);
        model_step(pw, iw, fl, rv, rpc, ak, rd);
        #1 check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    // Assert reset between clock edges and check its immediate effect
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        mem_busy = 1'b0;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_inst", ifid_inst, NOP_INST);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          pw;
        bit          iw;
        bit          rv;
        logic [31:0] rpc;
        int unsigned r;
        int          n;

        // Reset and zero-wait streaming
        lat = 0;
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        chk("first_valid", {31'b0, ifid_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("stream_pc", ifid_pc, 32'(k * 4));
            chk("stream_valid", {31'b0, ifid_valid}, 32'd1);
        end

        // Two stall cycles while fetching 0x10
        chk("stall_addr", imem_addr, 32'h10);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("stall_frozen", ifid_pc, 32'h0C);
        chk("stall_noreq", {31'b0, imem_req}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("unstall_pc", ifid_pc, 32'h10);
        chk("unstall_inst", ifid_inst, word(32'h10));

        // Ack three cycles late
        lat = 3;
        run(3);
        chk("slow_hold_pc", ifid_pc, 32'h10);
        chk("slow_addr", imem_addr, 32'h14);
        run(1);
        chk("slow_pc", ifid_pc, 32'h14);
        chk("slow_next", imem_addr, 32'h18);

        // Redirect plus flush while waiting on a slow response
        run(1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        chk("rd_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rd_inst", ifid_inst, NOP_INST);
        chk("rd_oldaddr", imem_addr, 32'h18);
        lat = 0;
        n = 0;
        while (imem_addr !== 32'h200 && n < 8) begin
            run(1);
            chk("drop_valid", {31'b0, ifid_valid}, 32'd0);
            n++;
        end
        chk("rd_newaddr", imem_addr, 32'h200);
        run(1);
        chk("rd_fetch_pc", ifid_pc, 32'h200);
        chk("rd_fetch_inst", ifid_inst, word(32'h200));

        // Redirect near the top of memory with unaligned target
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        run(1);
        chk("wrap_top", ifid_pc, 32'hFFFF_FFFC);
        run(1);
        chk("wrap_zero", ifid_pc, 32'h0);

        // Reset in the middle of a slow request
        lat = 5;
        run(2);
        do_reset();
        lat = 0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("rr_addr", imem_addr, RESET_PC);
        chk("rr_valid", {31'b0, ifid_valid}, 32'd0);

        // Random hazards, redirects and memory latency
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            pw = 1'b1; iw = 1'b1; rv = 1'b0; rpc = '0;
            if (r < 20) begin
                pw = 1'b0; iw = 1'b0;
            end else if (r < 28) begin
                pw = 1'b0;
            end else if (r < 32) begin
                iw = 1'b0;
            end
            if ($urandom_range(0, 99) < 8) begin
                rv = 1'b1; rpc = $urandom;
            end
            cycle(pw, iw, rv, rv, rpc);
        end

`ifdef FETCH_PERF_CNT_EN
        // Counter totals after a known stall/flush mix
        lat = 0;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("perf_stall5", perf_stall_cnt, 32'd5);
        chk("perf_flush2", perf_flush_cnt, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
